// File: rtl/seg7_scan_if.sv
// Bundle of the digit load handshake and scan outputs between the
// timekeeping logic / segment lookup and the seg7_scan driver.
// master: timekeeping side (drives iDATA/iLOAD/iBLINK); slave: seg7_scan.
// Ports: iDATA packed digits, iLOAD update strobe, iBLINK per-digit blink,
//        oACK update applied, oDIG slot nibble, oAN active-low anodes,
//        oFRAME last clock of a frame.
interface seg7_scan_if #(
  parameter int NUM_DIG = 4
);
  logic [4*NUM_DIG-1:0] iDATA;
  logic                 iLOAD;
  logic [NUM_DIG-1:0]   iBLINK;
  logic                 oACK;
  logic [3:0]           oDIG;
  logic [NUM_DIG-1:0]   oAN;
  logic                 oFRAME;

  modport master (
    output iDATA, iLOAD, iBLINK,
    input  oACK, oDIG, oAN, oFRAME
  );

  modport slave (
    input  iDATA, iLOAD, iBLINK,
    output oACK, oDIG, oAN, oFRAME
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-coherent digit updates and blink.
// Latency: slot outputs are registered, 1 cycle behind prescaler/slot; updates land at the next frame boundary.
// Backpressure: none; iLOAD is always accepted (latest wins), oACK pulses once when applied.
// Ports: iCLK clock, iRST sync active-high reset, bus (seg7_scan_if.slave):
//   iDATA/iLOAD/iBLINK in, oACK/oDIG/oAN/oFRAME out.
// Optional: define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module seg7_scan #(
  parameter int NUM_DIG   = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD_CYC  = 4,
  parameter int BLINK_DIV = 25
) (
  input logic          iCLK,
  input logic          iRST,
  seg7_scan_if.slave   bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIG);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYC);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(NUM_DIG - 1);
  localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_DIV - 1);
  localparam logic [3:0]    BLANK     = 4'hB;

  logic [PW-1:0]            presc;
  logic [SW-1:0]            slot;
  logic [FW-1:0]            fcnt;
  logic                     phase;
  logic [NUM_DIG-1:0][3:0]  shadow;
  logic [NUM_DIG-1:0][3:0]  pend;
  logic                     pend_vld;

  logic [NUM_DIG-1:0]       an_q;
  logic [3:0]               dig_q;
  logic                     ack_q;
  logic                     frame_q;

  logic                     slot_end;
  logic                     boundary;
  logic                     dig_blank;

  assign slot_end = (presc == PRESC_MAX);
  assign boundary = slot_end && (slot == SLOT_MAX);

`ifdef SEG7_SCAN_LZB_EN
  // lzb[k] is set when digit k and every digit above it are zero; digit 0 always shows.
  logic [NUM_DIG-1:0] lzb;
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    lzb  = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      zrun   = zrun & (shadow[k] == 4'h0);
      lzb[k] = zrun;
    end
  end
  assign dig_blank = (phase & bus.iBLINK[slot]) | lzb[slot];
`else
  assign dig_blank = phase & bus.iBLINK[slot];
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      presc    <= '0;
      slot     <= '0;
      fcnt     <= '0;
      phase    <= 1'b0;
      shadow   <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      an_q     <= '1;
      dig_q    <= BLANK;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      if (slot_end) begin
        presc <= '0;
        slot  <= (slot == SLOT_MAX) ? '0 : slot + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (boundary) begin
        if (fcnt == FCNT_MAX) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      // A load on the boundary cycle bypasses the pending register so it
      // shows in the very next frame.
      if (bus.iLOAD) begin
        pend <= bus.iDATA;
      end
      if (boundary && (pend_vld || bus.iLOAD)) begin
        shadow   <= bus.iLOAD ? bus.iDATA : pend;
        pend_vld <= 1'b0;
      end else if (bus.iLOAD) begin
        pend_vld <= 1'b1;
      end

      ack_q   <= boundary && (pend_vld || bus.iLOAD);
      frame_q <= boundary;

      // Dead time at the start of every slot keeps the previous digit from
      // ghosting onto the next anode.
      if ((presc < DEAD_END) || dig_blank) begin
        an_q  <= '1;
        dig_q <= BLANK;
      end else begin
        an_q  <= ~(NUM_DIG'(1) << slot);
        dig_q <= shadow[slot];
      end
    end
  end

  assign bus.oAN    = an_q;
  assign bus.oDIG   = dig_q;
  assign bus.oACK   = ack_q;
  assign bus.oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: the driver computes each cycle's expected
// outputs from the cycle count since reset and pushes them; the monitor pops
// and compares on the falling edge.
module tb_seg7_scan;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 2;
  localparam int FR = ND * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIG(ND)) bus ();

  seg7_scan #(
    .NUM_DIG(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [ND-1:0] an;
    logic [3:0]    dig;
    logic          ack;
    logic          frame;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  // reference state: cycles since reset, displayed and pending digit words
  int              t = 0;
  logic [4*ND-1:0] m_shadow = '0;
  logic [4*ND-1:0] m_pend   = '0;
  bit              m_pflag  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("oAN",    32'(bus.oAN),    32'(e.an));
      chk("oDIG",   32'(bus.oDIG),   32'(e.dig));
      chk("oACK",   32'(bus.oACK),   32'(e.ack));
      chk("oFRAME", 32'(bus.oFRAME), 32'(e.frame));
      chk("anode_onehot", 32'($countones(~bus.oAN) <= 1), 32'd1);
    end
  end

  // Apply one cycle of stimulus and predict what the DUT registers on the coming edge.
  task automatic step(input bit r, input bit ld, input logic [4*ND-1:0] d, input logic [ND-1:0] bl);
    exp_t e;
    int   p, s, f;
    bit   ph, bnd, blank;
    rst        = r;
    bus.iLOAD  = ld;
    bus.iDATA  = d;
    bus.iBLINK = bl;
    e.an    = '1;
    e.dig   = 4'hB;
    e.ack   = 1'b0;
    e.frame = 1'b0;
    if (r) begin
      t = 0;
      m_shadow = '0;
      m_pend   = '0;
      m_pflag  = 1'b0;
    end else begin
      p   = t % SD;
      s   = (t / SD) % ND;
      f   = t / FR;
      ph  = ((f / BD) % 2) == 1;
      bnd = (t % FR) == FR - 1;
      blank = (p < DC) || (ph && bl[s]);
`ifdef SEG7_SCAN_LZB_EN
      if (s > 0 && (m_shadow >> (4 * s)) == '0) blank = 1'b1;
`endif
      if (!blank) begin
        e.an[s] = 1'b0;
        e.dig   = m_shadow[4*s +: 4];
      end
      e.ack   = bnd && (m_pflag || ld);
      e.frame = bnd;
      if (ld) begin
        m_pend  = d;
        m_pflag = 1'b1;
      end
      if (bnd && m_pflag) begin
        m_shadow = m_pend;
        m_pflag  = 1'b0;
      end
      t++;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [ND-1:0] bl);
    repeat (n) step(1'b0, 1'b0, '0, bl);
  endtask

  // Advance until the next cycle is at position pos within the frame.
  task automatic go_to(input int pos, input logic [ND-1:0] bl);
    while ((t % FR) != pos) step(1'b0, 1'b0, '0, bl);
  endtask

  initial begin
    logic [ND-1:0]   rb;
    logic [4*ND-1:0] rd;
    rst = 1'b1;
    bus.iLOAD = 1'b0;
    bus.iDATA = '0;
    bus.iBLINK = '0;
    #1;
    repeat (3) step(1'b1, 1'b0, '0, '0);

    // basic load, shown from the next frame
    step(1'b0, 1'b1, 16'h1234, '0);
    run(2 * FR, '0);

    // two loads mid-frame: latest wins, single ack
    go_to(SD + 3, '0);
    step(1'b0, 1'b1, 16'h1111, '0);
    go_to(2 * SD + 3, '0);
    step(1'b0, 1'b1, 16'h2222, '0);
    run(2 * FR, '0);

    // load on the boundary cycle itself
    go_to(FR - 1, '0);
    step(1'b0, 1'b1, 16'h5678, '0);
    run(FR + 5, '0);

    // blink on digits 0 and 1
    run(8 * FR, 4'b0011);

    // reset in slot 2 with an update pending
    go_to(SD + 1, '0);
    step(1'b0, 1'b1, 16'h9abc, '0);
    go_to(2 * SD + 2, '0);
    step(1'b1, 1'b0, '0, '0);
    run(2 * FR, '0);
    step(1'b0, 1'b1, 16'hfedc, '0);
    run(2 * FR, '0);

`ifdef SEG7_SCAN_LZB_EN
    step(1'b0, 1'b1, 16'h0050, '0);
    run(2 * FR, '0);
    step(1'b0, 1'b1, 16'h0000, '0);
    run(2 * FR, '0);
`endif

    // randomized traffic
    rb = '0;
    repeat (1500) begin
      if ($urandom_range(0, 29) == 0) rb = ND'($urandom);
      rd = (4*ND)'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, rd, rb);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
